// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Holds the RISC-V opcode constants, the immediate format codes carried
// with every result, and the XLEN helpers used by the decoder.
package imm_gen_pipe_pkg;

  // Supported output widths.
  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  // Base-ISA major opcodes, inst[6:0].
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 values that turn OP-IMM into a shift-immediate.
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    T_R     = 3'd0,
    T_I     = 3'd1,
    T_S     = 3'd2,
    T_B     = 3'd3,
    T_U     = 3'd4,
    T_J     = 3'd5,
    T_SHAMT = 3'd6,
    T_ILL   = 3'd7
  } imm_type_e;

  // Top bit of the shift-amount field: RV64 uses inst[25:20], RV32 inst[24:20].
  function automatic int shamt_msb(input int xlen);
    return (xlen == XLEN_64) ? 25 : 24;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between fetch/decode, the immediate generator and the
// ALU-operand mux.
//   in_valid/in_ready/in_inst        : instruction input channel
//   out_valid/out_ready/out_imm/
//   out_type/out_illegal             : decoded result channel
// Handshake: on each channel a transfer happens on a rising clk edge where
// valid and ready are both 1. valid never depends combinationally on ready;
// the payload is only meaningful while valid is 1.
interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_type_e       out_type;
  logic            out_illegal;

  // Producer of instructions / consumer of immediates.
  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal
  );

  // The immediate generator itself.
  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational instruction-to-immediate decoder.
//   inst_i    : 32-bit instruction word
//   imm_o     : immediate extended to XLEN
//   type_o    : format code
//   illegal_o : opcode not recognised
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o,
  output logic            illegal_o
);

  localparam int SH_MSB = shamt_msb(XLEN);

  // Every format fits in 32 bits; widening a signed value sign-extends,
  // which covers U-type on RV64 as well. Shift amounts keep bit 31 clear.
  logic signed [31:0] imm32;

  always_comb begin
    imm32     = '0;
    type_o    = T_R;
    illegal_o = 1'b0;
    unique case (inst_i[6:0])
      OPC_LOAD, OPC_JALR: begin
        imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
        type_o = T_I;
      end
      OPC_OP_IMM: begin
        if (inst_i[14:12] == F3_SLLI || inst_i[14:12] == F3_SRXI) begin
          imm32[SH_MSB-20:0] = inst_i[SH_MSB:20];
          type_o             = T_SHAMT;
        end else begin
          imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
          type_o = T_I;
        end
      end
      OPC_STORE: begin
        imm32  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        type_o = T_S;
      end
      OPC_BRANCH: begin
        imm32  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
        type_o = T_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32  = {inst_i[31:12], 12'b0};
        type_o = T_U;
      end
      OPC_JAL: begin
        imm32  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};
        type_o = T_J;
      end
      OPC_OP: begin
        type_o = T_R;
      end
      default: begin
        type_o    = T_ILL;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes accepted instructions and queues
// the results in an elastic FIFO so fetch/decode can be back-pressured.
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : instruction in / immediate out handshake (slave side)
//   illegal_cnt : saturating count of accepted illegal instructions
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (bus.in_inst),
    .imm_o     (dec_imm),
    .type_o    (dec_type),
    .illegal_o (dec_ill)
  );

  logic [XLEN-1:0] imm_mem_q  [DEPTH];
  imm_type_e       type_mem_q [DEPTH];
  logic            ill_mem_q  [DEPTH];

  // Extra MSB on the pointers distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Copy of the most recently popped entry, shown while the FIFO is empty.
  logic [XLEN-1:0] last_imm_q;
  imm_type_e       last_type_q;
  logic            last_ill_q;

  logic full, empty, push, pop;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign push   = bus.in_valid && !full;
  assign pop    = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push && dec_ill && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      last_imm_q  <= '0;
      last_type_q <= T_R;
      last_ill_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i]  <= '0;
        type_mem_q[i] <= T_R;
        ill_mem_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        imm_mem_q[wr_idx]  <= dec_imm;
        type_mem_q[wr_idx] <= dec_type;
        ill_mem_q[wr_idx]  <= dec_ill;
      end
      if (pop) begin
        last_imm_q  <= imm_mem_q[rd_idx];
        last_type_q <= type_mem_q[rd_idx];
        last_ill_q  <= ill_mem_q[rd_idx];
      end
    end
  end

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.out_imm     = empty ? last_imm_q  : imm_mem_q[rd_idx];
  assign bus.out_type    = empty ? last_type_q : type_mem_q[rd_idx];
  assign bus.out_illegal = empty ? last_ill_q  : ill_mem_q[rd_idx];
  assign illegal_cnt     = cnt_q;

endmodule
